// File: rtl/word_bit_serializer.sv
// word_bit_serializer
// Parallel-to-serial front end for the serial sequence detectors. Words arrive
// over a valid/ready handshake and leave one bit per consumed cycle on a_out.
// A one-word holding buffer, plus a bypass load on the last bit, keeps the
// bit stream gap-free while the producer keeps offering words.

module word_bit_serializer #(
    parameter int   W         = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         bit_en,
    output logic         a_out,
    output logic         bit_valid,
    output logic         word_start,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // IDLE: nothing to send; SHIFT: one word in sh; SHIFT_FULL: sh plus hold.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_SHIFT      = 2'b01,
        ST_SHIFT_FULL = 2'b10
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [W-1:0]   sh_r;
    logic [W-1:0]   sh_nx_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  cnt_nx_s;
    logic [W-1:0]   hold_r;
    logic [W-1:0]   hold_nx_s;

    logic           active_s;
    logic           hold_v_s;
    logic           fire_s;
    logic           adv_s;
    logic           last_s;

    // Moves the shift register one place toward the output end, zero fill.
    function automatic logic [W-1:0] shift_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        if (MSB_FIRST) begin
            r = {w[W-2:0], 1'b0};
        end else begin
            r = {1'b0, w[W-1:1]};
        end
        return r;
    endfunction

    // Decode the control state into the active / buffer-valid flags.
    always_comb begin
        active_s = 1'b0;
        hold_v_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                active_s = 1'b0;
                hold_v_s = 1'b0;
            end
            ST_SHIFT: begin
                active_s = 1'b1;
                hold_v_s = 1'b0;
            end
            ST_SHIFT_FULL: begin
                active_s = 1'b1;
                hold_v_s = 1'b1;
            end
            default: begin
                active_s = 1'b0;
                hold_v_s = 1'b0;
            end
        endcase
    end

    // Handshake and bit-consumption qualifiers.
    always_comb begin
        fire_s = in_valid & in_ready;
        adv_s  = active_s & bit_en;
        last_s = adv_s & (cnt_r == CNT_LAST);
    end

    // Next-state logic for the control FSM and its datapath registers.
    always_comb begin
        state_nx_s = state_r;
        sh_nx_s    = sh_r;
        cnt_nx_s   = cnt_r;
        hold_nx_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (fire_s) begin
                    sh_nx_s    = in_data;
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    if (fire_s) begin
                        // Bypass: the new word goes straight into sh, no gap.
                        sh_nx_s    = in_data;
                        cnt_nx_s   = {CW{1'b0}};
                        state_nx_s = ST_SHIFT;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    if (adv_s) begin
                        sh_nx_s  = shift_word(sh_r);
                        cnt_nx_s = cnt_r + CW'(1);
                    end else begin
                        sh_nx_s  = sh_r;
                    end
                    if (fire_s) begin
                        hold_nx_s  = in_data;
                        state_nx_s = ST_SHIFT_FULL;
                    end else begin
                        state_nx_s = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT_FULL: begin
                if (last_s) begin
                    sh_nx_s    = hold_r;
                    cnt_nx_s   = {CW{1'b0}};
                    state_nx_s = ST_SHIFT;
                end else if (adv_s) begin
                    sh_nx_s    = shift_word(sh_r);
                    cnt_nx_s   = cnt_r + CW'(1);
                    state_nx_s = ST_SHIFT_FULL;
                end else begin
                    state_nx_s = ST_SHIFT_FULL;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state.
                sh_nx_s    = {W{1'b0}};
                cnt_nx_s   = {CW{1'b0}};
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset drops any active or buffered word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            sh_r    <= {W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            hold_r  <= {W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            sh_r    <= sh_nx_s;
            cnt_r   <= cnt_nx_s;
            hold_r  <= hold_nx_s;
        end
    end

    // Outputs depend on registers only (plus reset gating of in_ready).
    always_comb begin
        in_ready   = rst & ~hold_v_s;
        bit_valid  = active_s;
        word_start = active_s & (cnt_r == {CW{1'b0}});
        busy       = active_s | hold_v_s;
        if (!active_s) begin
            a_out = IDLE_BIT;
        end else if (MSB_FIRST) begin
            a_out = sh_r[W-1];
        end else begin
            a_out = sh_r[0];
        end
    end

endmodule

// File: tb/tb_word_bit_serializer.sv
// Directed bench for word_bit_serializer: table-driven stall check plus
// hand-written streaming, bit-order, bypass, backpressure and reset sequences.

module tb_word_bit_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       bit_en = 1'b0;

    logic in_ready, a_out, bit_valid, word_start, busy;
    logic l_in_ready, l_a_out, l_bit_valid, l_word_start, l_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    word_bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .bit_en(bit_en), .a_out(a_out),
        .bit_valid(bit_valid), .word_start(word_start), .busy(busy)
    );

    word_bit_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .bit_en(bit_en), .a_out(l_a_out),
        .bit_valid(l_bit_valid), .word_start(l_word_start), .busy(l_busy)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       en;
        logic       a;
        logic       bv;
        logic       ws;
        logic       bsy;
        logic       rdy;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Apply inputs for the next posedge and return at the following negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic en);
        in_valid = v;
        in_data  = d;
        bit_en   = en;
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic a, input logic bv,
                           input logic ws, input logic bsy, input logic rdy);
        chk({tag, ".a_out"}, a_out, a);
        chk({tag, ".bit_valid"}, bit_valid, bv);
        chk({tag, ".word_start"}, word_start, ws);
        chk({tag, ".busy"}, busy, bsy);
        chk({tag, ".in_ready"}, in_ready, rdy);
    endtask

    initial begin
        logic [23:0] sbits;
        logic [15:0] bbits;
        logic [23:0] pbits;
        logic [7:0]  dsel;

        // Stall vectors: word 0xA5 = 1010_0101, bit_en alternating after load.
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Power-on reset.
        @(negedge clk);
        @(negedge clk);
        chk_all("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("por_release.in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Streaming 0x35, 0x99, 0xA8 back to back with bit_en held high.
        sbits = 24'h3599A8;
        for (int i = 0; i <= 24; i++) begin
            if (i == 0)      dsel = 8'h35;
            else if (i == 1) dsel = 8'h99;
            else             dsel = 8'hA8;
            step(i <= 9, dsel, 1'b1);
            if (i < 24) begin
                chk($sformatf("stream[%0d].a_out", i), a_out, sbits[23-i]);
                chk($sformatf("stream[%0d].bit_valid", i), bit_valid, 1'b1);
                chk($sformatf("stream[%0d].word_start", i), word_start, (i % 8) == 0);
                chk($sformatf("stream[%0d].in_ready", i), in_ready,
                    (i == 0) || (i == 8) || (i >= 16));
            end else begin
                chk_all("stream_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        // Stall: table-driven, each bit held two cycles.
        for (int r = 0; r < 17; r++) begin
            step(tbl[r].v, tbl[r].d, tbl[r].en);
            chk_all($sformatf("stall[%0d]", r), tbl[r].a, tbl[r].bv,
                    tbl[r].ws, tbl[r].bsy, tbl[r].rdy);
        end

        // Bit order on the LSB-first instance: 0x01 -> 1 then seven 0s.
        for (int i = 0; i <= 8; i++) begin
            step(i == 0, 8'h01, 1'b1);
            chk($sformatf("lsb[%0d].a_out", i), l_a_out, i == 0);
            chk($sformatf("lsb[%0d].bit_valid", i), l_bit_valid, i < 8);
            chk($sformatf("lsb[%0d].word_start", i), l_word_start, i == 0);
        end

        // Bypass: 0x3C offered only while the last bit of 0xC3 is consumed.
        bbits = 16'hC33C;
        for (int i = 0; i <= 16; i++) begin
            step((i == 0) || (i == 8), (i == 0) ? 8'hC3 : 8'h3C, 1'b1);
            if (i < 16) begin
                chk_all($sformatf("bypass[%0d]", i), bbits[15-i], 1'b1,
                        (i % 8) == 0, 1'b1, 1'b1);
            end else begin
                chk_all("bypass_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        // Backpressure: bit_en low, three words offered.
        step(1'b1, 8'h11, 1'b0);
        chk("bp_load.in_ready", in_ready, 1'b1);
        step(1'b1, 8'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h33, 1'b0);
            chk_all($sformatf("bp_stall[%0d]", i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        pbits = 24'h112233;
        for (int i = 1; i <= 24; i++) begin
            step(i <= 9, 8'h33, 1'b1);
            if (i < 24) begin
                chk($sformatf("bp[%0d].a_out", i), a_out, pbits[23-i]);
                chk($sformatf("bp[%0d].bit_valid", i), bit_valid, 1'b1);
                chk($sformatf("bp[%0d].in_ready", i), in_ready, (i == 8) || (i >= 16));
            end else begin
                chk_all("bp_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        // Reset mid-word with a buffered word pending.
        step(1'b1, 8'h5A, 1'b1);
        step(1'b1, 8'h66, 1'b1);
        chk("mid.busy_pre", busy, 1'b1);
        chk("mid.in_ready_pre", in_ready, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("mid_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_release.in_ready", in_ready, 1'b1);
        chk("mid_release.busy", busy, 1'b0);
        for (int i = 0; i <= 8; i++) begin
            step(i == 0, 8'hFF, 1'b1);
            if (i < 8) begin
                chk_all($sformatf("ff[%0d]", i), 1'b1, 1'b1, i == 0, 1'b1, 1'b1);
            end else begin
                chk_all("ff_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/word_bit_serializer.md
# word_bit_serializer

Parallel-to-serial front end for the serial sequence-detector FSMs. It accepts W-bit words over a valid/ready handshake and presents them one bit per consumed cycle on `a_out`, which drives a detector's `a` input directly. A one-word holding buffer plus a last-bit bypass keep the bit stream gap-free while the producer keeps `in_valid` high.

## Interface
- `W`, 8: word width; legal range W ≥ 2.
- `MSB_FIRST`, 1: 1 sends bit W-1 first; 0 sends bit 0 first.
- `IDLE_BIT`, 1'b0: value driven on `a_out` while no word is active.

- `clk`  in  1  clock; all state changes on posedge.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  W  word to serialize.
- `bit_en`  in  1  consumer takes the current bit at this posedge.
- `a_out`  out  1  current serial bit.
- `bit_valid`  out  1  `a_out` carries a data bit, not the idle fill.
- `word_start`  out  1  `a_out` carries the first bit of a word.
- `busy`  out  1  a word is active or buffered.

## Operation
- State:
  - `sh[W-1:0]`: shift register.
  - `cnt`: bit index, 0..W-1, width $clog2(W).
  - `hold[W-1:0]` and `hold_v`: holding buffer.
  - `active`: a word is being sent.
- Control FSM:
  - IDLE: `active`=0, `hold_v`=0.
  - SHIFT: `active`=1, `hold_v`=0.
  - SHIFT_FULL: `active`=1, `hold_v`=1.
- Derived signals:
  - fire = `in_valid` & `in_ready`.
  - adv = `active` & `bit_en`.
  - last = adv & (`cnt`==W-1).
- Outputs, all combinational from registers only (no input-to-output paths):
  - `in_ready` = ~`hold_v`, forced to 0 while `rst` is low.
  - `a_out` = `active` ? (MSB_FIRST ? `sh[W-1]` : `sh[0]`) : IDLE_BIT.
  - `bit_valid` = `active`.
  - `word_start` = `active` & (`cnt`==0).
  - `busy` = `active` | `hold_v`.
- Transitions:
  - IDLE, fire: `sh` ← `in_data`, `cnt` ← 0. Go to SHIFT.
  - SHIFT, adv & ~last: shift `sh` toward the output end, `cnt`++.
  - SHIFT, fire & ~last: `hold` ← `in_data`. Go to SHIFT_FULL.
  - SHIFT, last & fire: bypass, `sh` ← `in_data`, `cnt` ← 0. Stay in SHIFT.
  - SHIFT, last & ~fire: go to IDLE, `a_out` returns to IDLE_BIT.
  - SHIFT_FULL, adv & ~last: shift `sh` and `cnt`++ as in SHIFT. No fire is possible because `in_ready`=0.
  - SHIFT_FULL, last: `sh` ← `hold`, `cnt` ← 0, `hold_v` ← 0. Go to SHIFT.
  - Shift with `bit_en`=0: `sh` and `cnt` hold, and `a_out` stays stable indefinitely.
- Shift fill value is 0. It is never observable.
- Words are sent in acceptance order. No word is dropped or duplicated.

## Timing
- Reset (async assert, value on asserting edge): `sh`=0, `cnt`=0, `hold_v`=0, `active`=0.
  - Outputs during reset: `a_out`=IDLE_BIT, `bit_valid`=0, `word_start`=0, `busy`=0, `in_ready`=0.
  - Reset mid-word discards both the active word and the buffered word.
  - `in_ready`=1 in the first cycle after `rst` deasserts.
- Latency: a word accepted at edge k shows its first bit on `a_out` from just after edge k.
  - The consumer samples it at edge k+1 if `bit_en`=1.
- Gap-free streaming: with `bit_en`=1 and a word available, either in `hold` or via fire at the last bit, `bit_valid` stays high across word boundaries.
  - Throughput is 1 bit per cycle.
- Simultaneous last bit and fire with `hold_v`=0: bypass load. This is not a buffer write.
- `in_data` is sampled only on fire. Its value at any other time is don't-care, including X.

## Test plan
- Reset: assert `rst` low mid-word.
  - During reset: `a_out`=IDLE_BIT, `bit_valid`=0, `in_ready`=0, `busy`=0.
  - Next cycle after release: `in_ready`=1.
  - A fresh word 0xFF then serializes as 8 ones, with no remnant of the aborted words.
- Streaming: W=8, MSB_FIRST=1, `bit_en`=1, words 0x35, 0x99, 0xA8 offered back-to-back.
  - `a_out` = 0011_0101_1001_1001_1010_1000 with 24 contiguous `bit_valid` cycles.
  - `word_start` high at bit indices 0, 8 and 16.
  - Fed into detect_4/detect_6 detectors, they reproduce their expected detection patterns.
- Stall: word 0xA5 with `bit_en` toggling 1,0,1,0…
  - Each bit is held exactly 2 cycles.
  - `word_start` is high for the first 2 cycles only.
  - `busy` falls after 16 cycles.
- Bit order: MSB_FIRST=0, word 0x01.
  - `a_out` = 1 then 0000000.
  - Followed by IDLE_BIT with `bit_valid`=0.
- Bypass: send 0xC3 alone, then raise `in_valid` with 0x3C only in the cycle where `cnt`=7.
  - 0x3C bits follow with no idle cycle.
  - `hold_v` is never set.
- Backpressure: hold `bit_en`=0 and offer 3 words.
  - The first two are accepted (shift register + hold).
  - `in_ready`=0 while the third is pending.
  - After re-enabling `bit_en`, the third is accepted 8 cycles later.
  - Output order is preserved.
